// File: rtl/adc_capture_seq.sv
// One-shot RFDC snapshot: capture a window of stream words into RAM on trigger/arm, optionally
// aligned to SYSREF plus a programmable delay, then play it back one 12-bit sample per clock.
module adc_capture_seq #(
  parameter int unsigned WINDOW_WORDS = 64,
  parameter int unsigned LANES        = 8,
  parameter int unsigned DELAY_BITS   = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [LANES*16-1:0]   adc_tdata,
  input  logic                  adc_tvalid,
  input  logic                  sysref_in,
  input  logic                  trigger_in,
  output logic                  trigger_ack,
  input  logic                  arm,
  input  logic                  use_sysref,
  input  logic [DELAY_BITS-1:0] delay,
  output logic [11:0]           adc_out,
  output logic                  adc_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned AW = (WINDOW_WORDS > 1) ? $clog2(WINDOW_WORDS) : 1;
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned DW = LANES * 16;

  localparam logic [AW-1:0]         LastWord = AW'(WINDOW_WORDS - 1);
  localparam logic [LW-1:0]         LastLane = LW'(LANES - 1);
  localparam logic [AW-1:0]         AddrOne  = AW'(1);
  localparam logic [LW-1:0]         LaneOne  = LW'(1);
  localparam logic [DELAY_BITS-1:0] DlyOne   = DELAY_BITS'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSr,
    StDelay,
    StCapture,
    StPlayout,
    StDone
  } state_e;

  state_e                state_q;
  logic                  trig_q;
  logic                  sysref_q;
  logic                  sr_first_q;
  logic [DELAY_BITS-1:0] delay_q;
  logic [DELAY_BITS-1:0] dly_cnt_q;
  logic [AW-1:0]         wr_addr_q;
  logic [AW-1:0]         rd_word_q;
  logic [LW-1:0]         rd_lane_q;
  logic                  rd_run_q;
  logic [DW-1:0]         rd_data_q;
  logic                  va_q;
  logic [LW-1:0]         lane_a_q;
  logic                  last_a_q;
  logic                  last_b_q;
  logic [11:0]           adc_out_q;
  logic                  adc_valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DW-1:0] ram_q [WINDOW_WORDS];

  logic        start_evt;
  logic        sr_edge;
  logic        ram_we;
  logic        rd_en;
  logic        rd_last;
  logic [11:0] lane_sample;

  assign start_evt = (trigger_in & ~trig_q) | arm;
  assign sr_edge   = sysref_in & ~sysref_q;
  assign ram_we    = (state_q == StCapture) & adc_tvalid;
  assign rd_en     = (state_q == StPlayout) & rd_run_q;
  assign rd_last   = (rd_word_q == LastWord) & (rd_lane_q == LastLane);

  // Lane k occupies bits [16k+15:16k]; the top 12 bits start at offset 16k+4.
  always_comb begin
    lane_sample = rd_data_q[{lane_a_q, 4'b0100} +: 12];
  end

  // Window storage: never reset, holds only the latest capture.
  always_ff @(posedge aclk) begin
    if (ram_we) begin
      ram_q[wr_addr_q] <= adc_tdata;
    end
    rd_data_q <= ram_q[rd_word_q];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      sysref_q    <= 1'b0;
      sr_first_q  <= 1'b0;
      delay_q     <= '0;
      dly_cnt_q   <= '0;
      wr_addr_q   <= '0;
      rd_word_q   <= '0;
      rd_lane_q   <= '0;
      rd_run_q    <= 1'b0;
      va_q        <= 1'b0;
      lane_a_q    <= '0;
      last_a_q    <= 1'b0;
      last_b_q    <= 1'b0;
      adc_out_q   <= '0;
      adc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      trig_q   <= trigger_in;
      sysref_q <= sysref_in;
      done_q   <= 1'b0;

      // Two-stage playout pipe: RAM read, then lane select into the output register.
      va_q        <= rd_en;
      lane_a_q    <= rd_lane_q;
      last_a_q    <= rd_en & rd_last;
      last_b_q    <= va_q & last_a_q;
      adc_valid_q <= va_q;
      if (va_q) begin
        adc_out_q <= lane_sample;
      end

      unique case (state_q)
        StIdle: begin
          if (start_evt) begin
            delay_q   <= delay;
            dly_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (use_sysref) begin
              state_q    <= StWaitSr;
              sr_first_q <= 1'b1;
            end else begin
              state_q <= StDelay;
            end
          end
        end

        StWaitSr: begin
          sr_first_q <= 1'b0;
          // An edge coincident with entry is ignored.
          if (!sr_first_q && sr_edge) begin
            state_q <= StDelay;
          end
        end

        StDelay: begin
          if (dly_cnt_q == delay_q) begin
            state_q <= StCapture;
          end else begin
            dly_cnt_q <= dly_cnt_q + DlyOne;
          end
        end

        StCapture: begin
          if (adc_tvalid) begin
            wr_addr_q <= wr_addr_q + AddrOne;
            if (wr_addr_q == LastWord) begin
              state_q   <= StPlayout;
              rd_run_q  <= 1'b1;
              rd_word_q <= '0;
              rd_lane_q <= '0;
            end
          end
        end

        StPlayout: begin
          if (rd_run_q) begin
            if (rd_lane_q == LastLane) begin
              rd_lane_q <= '0;
              if (rd_word_q == LastWord) begin
                rd_run_q <= 1'b0;
              end else begin
                rd_word_q <= rd_word_q + AddrOne;
              end
            end else begin
              rd_lane_q <= rd_lane_q + LaneOne;
            end
          end
          if (last_b_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end

        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          wr_addr_q <= '0;
          rd_word_q <= '0;
          rd_lane_q <= '0;
          rd_run_q  <= 1'b0;
          dly_cnt_q <= '0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trigger_ack = trig_q;
  assign adc_out     = adc_out_q;
  assign adc_valid   = adc_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/adc_capture_seq.md
Name: adc_capture_seq

Overview:
Sequences one-shot ADC snapshot captures from the RFDC AXI4-Stream for debug readout through the ILA.
- On a trigger (ILA trig_out or software arm), optionally waits for a SYSREF rising edge plus a programmable delay.
- Stores a fixed window of 128-bit stream words in internal RAM.
- Plays the window back as one 12-bit sample per clock with a valid strobe.
- Sits in the aclk domain between the RFDC m00_axis output, the PL-captured SYSREF register and the ILA.

Parameters:
WINDOW_WORDS, 64, number of 128-bit stream words captured per shot (power of 2, 2..1024).
LANES, 8, 16-bit samples per stream word.
DELAY_BITS, 16, width of the post-SYSREF delay counter.

Ports:
aclk  in  1  ADC AXI4-Stream clock; all logic on rising edge.
areset  in  1  asynchronous active-high reset.
adc_tdata  in  128  RFDC stream data; lane k = bits [16k+15:16k], samples left-justified.
adc_tvalid  in  1  stream valid; there is no tready, so data is never back-pressured.
sysref_in  in  1  SYSREF already registered in aclk domain (level).
trigger_in  in  1  ILA trig_out (level).
trigger_ack  out  1  ILA trig_out_ack.
arm  in  1  software trigger, single-cycle pulse.
use_sysref  in  1  1 = align capture start to SYSREF rising edge.
delay  in  DELAY_BITS  cycles to wait after alignment point.
adc_out  out  12  played-back sample = lane[15:4].
adc_valid  out  1  adc_out valid.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after last sample played.

Behaviour:
Reset: all outputs 0, FSM in IDLE, all counters 0. Reset asserted mid-operation aborts immediately with no partial playout.

Trigger detection:
- Start event = rising edge of trigger_in (registered compare) OR arm, sampled in IDLE only.
- Start events in other states are ignored.
- trigger_in held high never retriggers.

trigger_ack = trigger_in delayed one cycle (level follow), independent of FSM state.

At the start event, latch use_sysref and delay into internal registers.

FSM states:
- IDLE: on start event, go to WAIT_SR if latched use_sysref=1, else DELAY.
- WAIT_SR: watch for a sysref_in rising edge (sysref_in=1 while the previous-cycle copy = 0). On the edge, go to DELAY. An edge present in the same cycle the FSM enters WAIT_SR is not counted.
- DELAY: counter counts from 0 each cycle. When counter == latched delay, go to CAPTURE. delay=0 therefore spends exactly one cycle in DELAY.
- CAPTURE: each cycle with adc_tvalid=1, write adc_tdata to RAM[wr_addr] and increment wr_addr. Cycles with tvalid=0 do not write. When the write to address WINDOW_WORDS-1 occurs, go to PLAYOUT.
- PLAYOUT: read RAM with one-cycle latency. For each word, emit lanes 0..LANES-1 in order, one per cycle.
  - adc_valid goes high 2 cycles after entering PLAYOUT and stays high for exactly WINDOW_WORDS*LANES contiguous cycles, with no gaps.
  - After the final sample, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle the FSM returns to IDLE.

Outputs and counters:
- adc_out holds its last value when adc_valid=0.
- wr_addr and the read address/lane counters wrap to 0 on IDLE entry.
- The RAM holds only the most recent window and is not cleared by reset.

Test Plan:
- use_sysref=0, delay=0, tvalid=1 always, data word n = {8 lanes of (n*8+k)<<4}; pulse arm → 512 contiguous adc_valid cycles with adc_out = 0,1,...,511; done pulses once; busy falls with return to IDLE.
- use_sysref=1, delay=10, SYSREF rising edge at cycle T → first captured word is the one present at T+12 (1 edge + 11 DELAY cycles); playout samples match that word onward.
- Capture with adc_tvalid low every other cycle → captured words skip invalid cycles; playout still yields 512 samples in order.
- Raise trigger_in and hold it high for 2000 cycles → trigger_ack follows one cycle later; exactly one capture/playout occurs; pulsing arm while busy has no effect.
- Assert areset during CAPTURE (wr_addr=20) → next cycle all outputs 0 and busy=0; a new arm gives a full, correct window.
- Release trigger_in and raise it again after done → second capture occurs; trigger_ack tracks trigger_in with one-cycle lag throughout.
